// File: rtl/detector_arbiter.sv
// Round-robin arbiter/sequencer sharing one symbol detector: grants a session, clears the detector,
// forwards the owner's symbols with 1-cycle latency, and returns a tagged verdict; no backpressure on inputs.
module detector_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int TIMEOUT   = 15,
  parameter int DRAIN_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] sym_in,
  input  logic [NREQ-1:0]   sym_valid,
  input  logic [NREQ-1:0]   sym_last,
  output logic [NREQ-1:0]   gnt,
  output logic              det_clear,
  output logic [3:0]        det_sym,
  output logic              det_valid,
  input  logic              det_match,
  input  logic              det_fail,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_match,
  output logic              rsp_timeout,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            det_clear_q, det_clear_d;
  logic [3:0]      det_sym_q, det_sym_d;
  logic            det_valid_q, det_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_match_q, rsp_match_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic [3:0]      own_sym;
  logic            own_vld, own_last, own_req;
  logic            verdict_match, verdict_timeout;

  assign own_sym  = sym_in[int'(owner_q)*4 +: 4];
  assign own_vld  = sym_valid[owner_q];
  assign own_last = sym_last[owner_q];
  assign own_req  = req[owner_q];

  // Scan downward so the closest set bit after ptr is the last one written.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    det_sym_d       = det_sym_q;
    det_valid_d     = 1'b0;
    verdict_match   = 1'b0;
    verdict_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_id;
          ptr_d   = pick_id;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        det_sym_d   = own_sym;
        det_valid_d = own_vld;
        cnt_d       = own_vld ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        if (det_match) begin
          verdict_match = 1'b1;
          state_d       = RESP;
        end else if (det_fail) begin
          state_d = RESP;
        end else if (!own_req) begin
          state_d = IDLE;
        end else if (own_vld && own_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (!own_vld && cnt_q >= 8'(TIMEOUT - 1)) begin
          verdict_timeout = 1'b1;
          state_d         = RESP;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (det_match) begin
          verdict_match = 1'b1;
          state_d       = RESP;
        end else if (det_fail || cnt_q >= 8'(DRAIN_MAX - 1)) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    gnt_d = '0;
    if (state_d == CLEAR || state_d == RUN || state_d == DRAIN) begin
      gnt_d[owner_d] = 1'b1;
    end
    det_clear_d   = (state_d == CLEAR);
    rsp_valid_d   = (state_d == RESP);
    rsp_id_d      = rsp_valid_d ? owner_d : '0;
    rsp_match_d   = verdict_match;
    rsp_timeout_d = verdict_timeout;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= IDW'(NREQ - 1);
      gnt_q         <= '0;
      cnt_q         <= '0;
      det_clear_q   <= 1'b0;
      det_sym_q     <= '0;
      det_valid_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_match_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      det_clear_q   <= det_clear_d;
      det_sym_q     <= det_sym_d;
      det_valid_q   <= det_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_match_q   <= rsp_match_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign det_clear   = det_clear_q;
  assign det_sym     = det_sym_q;
  assign det_valid   = det_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_match   = rsp_match_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/detector_arbiter.md
# detector_arbiter

Round-robin arbiter and session sequencer that shares one 4-bit-symbol sequence detector between up to NREQ requesters. A requester wins a session, the arbiter clears the detector and forwards that requester's symbol stream, then returns a match or no-match verdict tagged with the requester's ID. It sits between the input sources and the shared detector, and is the only block that drives the detector's inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width (must equal clog2(NREQ))
- TIMEOUT, 15, consecutive RUN cycles without a valid symbol before the session is reclaimed (1..255)
- DRAIN_MAX, 3, cycles to wait for a verdict after the last symbol

- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- req  in  NREQ  per-requester session request (level)
- sym_in  in  4*NREQ  symbols; requester k uses bits [4k+3:4k], ordered {i4,i3,i2,i1}
- sym_valid  in  NREQ  symbol valid, per requester
- sym_last  in  NREQ  marks the final symbol of the stream; qualified by sym_valid
- gnt  out  NREQ  one-hot grant; all zero outside CLEAR/RUN/DRAIN
- det_clear  out  1  one-cycle detector restart pulse
- det_sym  out  4  registered forwarded symbol
- det_valid  out  1  registered forwarded valid
- det_match  in  1  detector reached its end state
- det_fail  in  1  detector fell back to its start state
- rsp_valid  out  1  one-cycle verdict strobe
- rsp_id  out  IDW  session owner; valid with rsp_valid
- rsp_match  out  1  1 = sequence matched
- rsp_timeout  out  1  1 = session reclaimed by timeout
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, RESP.
- IDLE: if req != 0, choose the first set bit scanning upward (with wrap) from ptr+1. Register the one-hot gnt and owner ID, set ptr = owner, go to CLEAR. If req == 0, stay.
- CLEAR: det_clear=1 for exactly 1 cycle, det_valid=0. Go to RUN.
- RUN: each cycle, det_sym <= sym_in[owner], det_valid <= sym_valid[owner]. Symbols from non-owners are ignored. Exits are evaluated in this priority order:
  1. det_match -> match=1, go to RESP.
  2. det_fail -> match=0, go to RESP.
  3. req[owner]=0 (abort) -> go to IDLE directly. No response is issued and gnt is cleared.
  4. sym_valid&sym_last[owner] -> the symbol is forwarded, go to DRAIN.
  5. Idle counter reaches TIMEOUT -> match=0, timeout=1, go to RESP.
- Idle counter: cleared on each owner sym_valid and on entry to RUN; incremented otherwise; saturates.
- DRAIN: det_valid=0. det_match -> match=1 to RESP; det_fail -> match=0 to RESP; after DRAIN_MAX cycles without either, match=0 to RESP. det_match and det_fail together -> match wins.
- RESP: rsp_valid=1, rsp_id=owner, rsp_match/rsp_timeout per the latched verdict, gnt=0. Go to IDLE.
- ptr reset value: NREQ-1, so requester 0 wins first after reset.
- Reset values:
  - state = IDLE
  - gnt, det_clear, det_sym, det_valid = 0
  - rsp_valid, rsp_id, rsp_match, rsp_timeout = 0
  - busy = 0
  - counters = 0
- Reset in any state aborts the session immediately with no response.

## Timing
- req sampled in IDLE at edge t -> gnt and det_clear high after t; RUN from t+1; the first symbol can be forwarded at edge t+2.
- Forwarding latency is 1 cycle: a symbol sampled at edge k is on det_sym/det_valid until edge k+1.
- det_match/det_fail are sampled in RUN and DRAIN only; they are ignored in IDLE, CLEAR and RESP.
- Verdict sampled at edge v -> rsp_valid high for exactly 1 cycle after v.
- Minimum gap between sessions: RESP plus one IDLE cycle, so a back-to-back grant follows 2 cycles after rsp_valid.
- With all requesters continuously requesting, grant order is 0,1,2,3,0,…

## Test plan
- Single session: req[2]=1, symbols 4'h4, 4'h9, 4'h0, det_match on the 3rd forwarded symbol -> gnt=4'b0100, one det_clear pulse, det_sym follows the inputs 1 cycle late, rsp_valid with rsp_id=2, rsp_match=1, rsp_timeout=0.
- Fairness: req=4'b1111 held for 8 sessions, each ended by det_fail -> rsp_id sequence 0,1,2,3,0,1,2,3, all rsp_match=0.
- Timeout: owner 1 sends no valid symbols for 15 RUN cycles -> rsp_valid with rsp_id=1, rsp_timeout=1, rsp_match=0.
- Last plus drain: owner 0 asserts sym_last, det_match arrives 2 cycles later -> rsp_match=1. Repeat with no verdict -> rsp_match=0 after 3 DRAIN cycles.
- Abort and simultaneity: owner drops req in RUN -> no rsp_valid, next grant goes to the following requester. det_match and det_fail in the same cycle -> rsp_match=1.
- Reset mid-RUN: reset=0 for 1 edge -> all outputs 0 and state IDLE on the next cycle. Requester 0 wins the next arbitration.
